// File: rtl/obstacle_scheduler.sv
// Falling-obstacle slot pool: spawns into the lowest free slot every SPAWN_PERIOD
// enabled frames, moves active slots down, and retires them on kill or bottom edge.
module obstacle_scheduler #(
  parameter int          NUM_SLOTS    = 4,
  parameter int          SPAWN_PERIOD = 60,
  parameter int          OBJ_SIZE     = 20,
  parameter int          OBJ_X_MIN    = 3,
  parameter int          OBJ_Y_MIN    = 3,
  parameter int          OBJ_Y_MAX    = 476,
  parameter int          LEVEL_SPAWNS = 8,
  parameter int          MAX_SPEED    = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                     Reset,
  input  logic                     frame_clk,
  input  logic                     enable,
  input  logic [NUM_SLOTS-1:0]     kill,
  output logic [NUM_SLOTS*10-1:0]  obj_x,
  output logic [NUM_SLOTS*10-1:0]  obj_y,
  output logic [NUM_SLOTS-1:0]     obj_active,
  output logic [9:0]               obj_size,
  output logic [2:0]               speed,
  output logic                     spawn_dropped,
  output logic                     escaped,
  output logic [15:0]              escape_count,
  output logic [15:0]              spawn_count
);

  localparam int TW = (SPAWN_PERIOD > 2) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SPAWN_PERIOD - 1);
  localparam logic [9:0]    Y_START    = 10'(OBJ_Y_MIN);
  localparam logic [9:0]    Y_RETIRE   = 10'(OBJ_Y_MAX - OBJ_SIZE);

  logic [NUM_SLOTS-1:0][9:0] x_q, x_d;
  logic [NUM_SLOTS-1:0][9:0] y_q, y_d;
  logic [NUM_SLOTS-1:0]      active_q, active_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [2:0]                speed_q, speed_d;
  logic                      dropped_q, dropped_d;
  logic                      escaped_q, escaped_d;
  logic [15:0]               esc_cnt_q, esc_cnt_d;
  logic [15:0]               spawn_cnt_q, spawn_cnt_d;

  logic        spawn_now;
  logic        taken;
  logic [3:0]  esc_n;
  logic [16:0] esc_sum;

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    active_d    = active_q;
    timer_d     = timer_q;
    lfsr_d      = lfsr_q;
    speed_d     = speed_q;
    dropped_d   = 1'b0;
    escaped_d   = 1'b0;
    esc_cnt_d   = esc_cnt_q;
    spawn_cnt_d = spawn_cnt_q;
    spawn_now   = 1'b0;
    taken       = 1'b0;
    esc_n       = '0;
    esc_sum     = '0;

    if (enable) begin
      lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      spawn_now = (timer_q == TIMER_LAST);
      timer_d   = spawn_now ? '0 : timer_q + 1'b1;

      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (active_q[i]) begin
          if (kill[i]) begin
            active_d[i] = 1'b0;
            y_d[i]      = Y_START;
          end else if (y_q[i] > Y_RETIRE) begin
            active_d[i] = 1'b0;
            y_d[i]      = Y_START;
            esc_n       = esc_n + 4'd1;
          end else begin
            y_d[i] = y_q[i] + {7'b0, speed_q};
          end
        end
      end

      // Eligibility uses the pre-edge active map, so a slot freed this edge waits.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (spawn_now && !active_q[i] && !taken) begin
          taken       = 1'b1;
          active_d[i] = 1'b1;
          y_d[i]      = Y_START;
          x_d[i]      = 10'(OBJ_X_MIN) + {1'b0, lfsr_q[8:0]};
        end
      end

      if (spawn_now && taken) begin
        if (spawn_cnt_q != 16'hFFFF) spawn_cnt_d = spawn_cnt_q + 16'd1;
        if ((spawn_cnt_d % 16'(LEVEL_SPAWNS)) == 16'd0 && speed_q < 3'(MAX_SPEED))
          speed_d = speed_q + 3'd1;
      end
      dropped_d = spawn_now && !taken;

      esc_sum   = {1'b0, esc_cnt_q} + {13'b0, esc_n};
      esc_cnt_d = esc_sum[16] ? 16'hFFFF : esc_sum[15:0];
      escaped_d = (esc_n != 4'd0);
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      x_q         <= '0;
      y_q         <= {NUM_SLOTS{Y_START}};
      active_q    <= '0;
      timer_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      speed_q     <= 3'd1;
      dropped_q   <= 1'b0;
      escaped_q   <= 1'b0;
      esc_cnt_q   <= '0;
      spawn_cnt_q <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      active_q    <= active_d;
      timer_q     <= timer_d;
      lfsr_q      <= lfsr_d;
      speed_q     <= speed_d;
      dropped_q   <= dropped_d;
      escaped_q   <= escaped_d;
      esc_cnt_q   <= esc_cnt_d;
      spawn_cnt_q <= spawn_cnt_d;
    end
  end

  assign obj_x         = x_q;
  assign obj_y         = y_q;
  assign obj_active    = active_q;
  assign obj_size      = 10'(OBJ_SIZE);
  assign speed         = speed_q;
  assign spawn_dropped = dropped_q;
  assign escaped       = escaped_q;
  assign escape_count  = esc_cnt_q;
  assign spawn_count   = spawn_cnt_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench for obstacle_scheduler: a frame-level reference model predicts
// every output after each edge; a monitor compares one entry per clock edge.
module tb_obstacle_scheduler;

  localparam int EW = 40 + 40 + 4 + 3 + 1 + 1 + 16 + 16 + 10;

  logic        Reset;
  logic        frame_clk;
  logic        enable;
  logic [3:0]  kill;
  logic [39:0] obj_x, obj_y;
  logic [3:0]  obj_active;
  logic [9:0]  obj_size;
  logic [2:0]  speed;
  logic        spawn_dropped, escaped;
  logic [15:0] escape_count, spawn_count;

  obstacle_scheduler dut (
    .Reset(Reset), .frame_clk(frame_clk), .enable(enable), .kill(kill),
    .obj_x(obj_x), .obj_y(obj_y), .obj_active(obj_active), .obj_size(obj_size),
    .speed(speed), .spawn_dropped(spawn_dropped), .escaped(escaped),
    .escape_count(escape_count), .spawn_count(spawn_count)
  );

  // clock / reset
  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  // reference model: obstacles as plain integers
  int m_x[4], m_y[4];
  bit m_act[4];
  int m_timer, m_lfsr, m_spd, m_esc, m_spw;
  bit m_drop, m_escd;

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_x[i] = 0; m_y[i] = 3; m_act[i] = 0;
    end
    m_timer = 0; m_lfsr = 'hACE1; m_spd = 1; m_esc = 0; m_spw = 0;
    m_drop = 0; m_escd = 0;
  endfunction

  function automatic void m_step(input bit en, input logic [3:0] k);
    int free_slot;
    int n_esc;
    bit attempt;
    m_drop = 0;
    m_escd = 0;
    if (!en) return;
    attempt = (m_timer == 59);
    m_timer = attempt ? 0 : m_timer + 1;
    free_slot = -1;
    for (int i = 0; i < 4; i++)
      if (!m_act[i] && free_slot < 0) free_slot = i;
    n_esc = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_act[i]) begin
        if (k[i]) begin
          m_act[i] = 0; m_y[i] = 3;
        end else if (m_y[i] > 476 - 20) begin
          m_act[i] = 0; m_y[i] = 3; n_esc++;
        end else begin
          m_y[i] += m_spd;
        end
      end
    end
    if (attempt) begin
      if (free_slot >= 0) begin
        m_act[free_slot] = 1;
        m_y[free_slot]   = 3;
        m_x[free_slot]   = 3 + (m_lfsr % 512);
        m_spw = (m_spw < 65535) ? m_spw + 1 : 65535;
        if (m_spw % 8 == 0 && m_spd < 4) m_spd++;
      end else begin
        m_drop = 1;
      end
    end
    m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
    m_esc  = (m_esc + n_esc > 65535) ? 65535 : m_esc + n_esc;
    m_escd = (n_esc > 0);
  endfunction

  function automatic logic [EW-1:0] m_pack();
    logic [39:0] xv, yv;
    logic [3:0]  av;
    for (int i = 0; i < 4; i++) begin
      xv[i*10 +: 10] = 10'(m_x[i]);
      yv[i*10 +: 10] = 10'(m_y[i]);
      av[i]          = m_act[i];
    end
    return {xv, yv, av, 3'(m_spd), m_drop, m_escd, 16'(m_esc), 16'(m_spw), 10'd20};
  endfunction

  // driver: inputs change on the falling edge, expectation for the next rising edge queued
  task automatic drive(input logic rst, input logic en, input logic [3:0] k);
    @(negedge frame_clk);
    Reset  = rst;
    enable = en;
    kill   = k;
    if (rst) m_reset();
    else     m_step(en, k);
    exp_q.push_back(m_pack());
  endtask

  task automatic drive_random(input int n);
    logic [3:0] k;
    for (int c = 0; c < n; c++) begin
      for (int b = 0; b < 4; b++) k[b] = ($urandom_range(0, 511) == 0);
      drive(1'b0, ($urandom_range(0, 9) != 0), k);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // reset asserted between edges must clear the pool without waiting for a clock
  task automatic mid_reset();
    @(negedge frame_clk);
    #2 Reset = 1'b1;
    #1;
    check("async_reset_active", 64'(obj_active), 64'd0);
    check("async_reset_spawn_count", 64'(spawn_count), 64'd0);
    check("async_reset_speed", 64'(speed), 64'd1);
    m_reset();
    exp_q.push_back(m_pack());
  endtask

  // monitor
  initial begin
    logic [EW-1:0] act_v, exp_v;
    forever begin
      @(posedge frame_clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {obj_x, obj_y, obj_active, speed, spawn_dropped, escaped,
                 escape_count, spawn_count, obj_size};
        chk_cnt++;
        if (act_v === exp_v) pass_cnt++;
        else $display("FAIL outputs@cycle%0d: got %0h expected %0h", cyc, act_v, exp_v);
      end
    end
  end

  // stimulus
  initial begin
    logic [3:0] k;
    Reset  = 1'b1;
    enable = 1'b0;
    kill   = '0;
    m_reset();
    #1;
    check("reset_active", 64'(obj_active), 64'd0);
    check("reset_y", 64'(obj_y), {24'd0, {4{10'd3}}});

    for (int c = 0; c < 3; c++) drive(1'b1, 1'b0, 4'b0);
    // clean run: first spawn on edge 60, slot 0 retires on edge 515
    for (int c = 0; c < 600; c++) drive(1'b0, 1'b1, 4'b0);
    drive_random(5000);
    // frozen window with kills toggling
    for (int c = 0; c < 100; c++) begin
      k = 4'($urandom_range(0, 15));
      drive(1'b0, 1'b0, k);
    end
    drive_random(4000);
    mid_reset();
    for (int c = 0; c < 2; c++) drive(1'b1, 1'b1, 4'b1111);
    drive_random(3500);

    @(posedge frame_clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("final_speed_ceiling", 64'(speed), 64'd4);
    check("obj_size_const", 64'(obj_size), 64'd20);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
Owns a pool of NUM_SLOTS falling-obstacle slots and sequences them once per frame: spawns, motion, retirement at the bottom edge, and kill on collision.
- Spawns a new obstacle into the lowest-index free slot every SPAWN_PERIOD enabled frames, at a pseudo-random X position.
- Advances every active slot downward at a shared speed that rises with the spawn count.
- Feeds the obstacle drawing logic (per-slot X/Y/active) and the game logic (escape/kill events and counters).

Parameters:
NUM_SLOTS, 4, number of obstacle slots (1..8)
SPAWN_PERIOD, 60, enabled frames between spawn attempts (>=2)
OBJ_SIZE, 20, obstacle edge length in pixels
OBJ_X_MIN, 3, spawn X offset
OBJ_Y_MIN, 3, spawn Y
OBJ_Y_MAX, 476, bottom limit
LEVEL_SPAWNS, 8, successful spawns per speed increment
MAX_SPEED, 4, speed ceiling in pixels/frame
LFSR_SEED, 16'hACE1, LFSR reset value (non-zero)

Ports:
Reset  in  1  asynchronous, active-high reset
frame_clk  in  1  clock, one edge per video frame
enable  in  1  1 = run; 0 = freeze all state
kill  in  NUM_SLOTS  per-slot collision kill
obj_x  out  NUM_SLOTS*10  slot i X at [10i+9:10i]
obj_y  out  NUM_SLOTS*10  slot i Y at [10i+9:10i]
obj_active  out  NUM_SLOTS  slot occupied
obj_size  out  10  constant OBJ_SIZE
speed  out  3  current step in pixels/frame
spawn_dropped  out  1  one-frame pulse: spawn attempt found no free slot
escaped  out  1  one-frame pulse: at least one slot retired at bottom
escape_count  out  16  total retired-at-bottom obstacles, saturating
spawn_count  out  16  total successful spawns, saturating

Behaviour:
- Reset (async, asserts immediately): obj_active=0; all obj_x=0; all obj_y=OBJ_Y_MIN; speed=1; timer=0; lfsr=LFSR_SEED; counters=0; pulses=0.
- All outputs are registered.
- enable=0 freezes everything, including timer, lfsr, slots, speed and counters. kill is ignored. Pulses are driven to 0.
- Per enabled edge, all decisions use pre-edge register values:
  - lfsr: 16-bit Galois right shift, polynomial taps 16'hB400; advances every enabled edge.
  - timer: counts 0..SPAWN_PERIOD-1. On the edge where timer==SPAWN_PERIOD-1, timer wraps to 0 and a spawn attempt occurs.
  - Spawn attempt: choose the lowest-index slot with obj_active=0.
    - That slot gets active=1, y=OBJ_Y_MIN, x=OBJ_X_MIN+{1'b0,lfsr[8:0]} (range 3..514, always <=OBJ_Y_MAX-wide safe). The pre-advance lfsr value is used.
    - spawn_count increments.
    - If no slot is free: no change and spawn_dropped=1.
  - Active slot, kill[i]=1: active<=0, y<=OBJ_Y_MIN. Not counted as an escape.
  - Active slot, else if y > OBJ_Y_MAX-OBJ_SIZE (456): active<=0, y<=OBJ_Y_MIN, escape_count increments.
  - Active slot, else: y<=y+speed.
  - Multiple slots escaping on one edge add their total to escape_count. escaped=1 if at least one escapes.
  - Slot freed this edge is not eligible for a spawn on the same edge.
  - kill on an inactive slot is ignored.
- Speed:
  - When a spawn makes spawn_count (new value) a multiple of LEVEL_SPAWNS, speed<=min(speed+1, MAX_SPEED).
  - New speed applies from the next edge.
- Arithmetic: y is 10-bit unsigned. Y cannot exceed 456+MAX_SPEED, so there is no wrap. Counters saturate at 16'hFFFF.
- Reset mid-operation clears all slots immediately. The first spawn after release occurs on the SPAWN_PERIOD-th enabled edge.

Test Plan:
- Reset release, enable=1 for 60 edges -> obj_active=4'b0001 after edge 60; obj_y[9:0]=3; obj_x[9:0]=3+lfsr[8:0], with lfsr per model after 59 advances; spawn_count=1.
- Continue with no kills -> slot0 y=3+k after edge 60+k. At edge 515 slot0 deactivates, escaped pulses for one frame, escape_count=1.
- Kill slot1 at y=100 while slot0 and slot2 are active -> obj_active bit1 clears, bit1 y=3, escape_count unchanged. Next spawn fills slot1 before slot3.
- Fill all 4 slots, hold them with no retirement (OBJ_Y_MAX large) -> 5th attempt gives spawn_dropped=1 for one frame, spawn_count stays 4.
- 8 spawns -> speed=2 from the following edge. After 24 spawns speed=4, and it stays 4 after 32 spawns.
- enable=0 for 100 frames mid-flight with kill pulsed -> all outputs unchanged. Reset asserted mid-frame -> obj_active=0 asynchronously.
